// File: rtl/dmem_loader.sv
// dmem_loader: write-side front end for the FIR sample memory (dmem).
// Latency: one cycle from accept to dmem write (registered mem_* outputs).
// Backpressure: in_ready is high only while loading; each accept writes one word.
// Optional running checksum of accepted samples: define DMEM_LOADER_CKSUM_EN.
module dmem_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 10240,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] sample_cnt,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_RESET = ADDR_W'(BASE);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] cnt_inc;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;
  logic              accept;
  logic              frame_start;

  // Handshake and status decode straight from the state register.
  always_comb begin
    in_ready    = (state_q == S_LOAD);
    busy        = (state_q == S_LOAD);
    done        = (state_q == S_DONE);
    accept      = (state_q == S_LOAD) && in_valid;
    frame_start = (state_q == S_IDLE) && start;
    cnt_inc     = cnt_q + ADDR_W'(1);
  end

  // Next-state, pointer and dmem strobe computation.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    cen_d    = 1'b1;
    wen_d    = 1'b1;
    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = frame_len;
          cnt_d   = '0;
          // An empty frame still reports completion, just without writes.
          state_d = (frame_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cen_d    = 1'b0;
          wen_d    = 1'b0;
          mem_a_d  = wr_ptr_q;
          mem_d_d  = in_data;
          wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_W'(1);
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and dmem interface registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wr_ptr_q <= PTR_RESET;
      cnt_q    <= '0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      mem_a_q  <= '0;
      mem_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      mem_a_q  <= mem_a_d;
      mem_d_q  <= mem_d_d;
    end
  end

`ifdef DMEM_LOADER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  // Running modular sum of accepted samples, cleared when a frame starts.
  always_comb begin
    cksum_d = cksum_q;
    if (frame_start) begin
      cksum_d = '0;
    end else if (accept) begin
      cksum_d = cksum_q + in_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign wr_ptr     = wr_ptr_q;
  assign sample_cnt = cnt_q;
  assign mem_cen    = cen_q;
  assign mem_wen    = wen_q;
  assign mem_a      = mem_a_q;
  assign mem_d      = mem_d_q;

endmodule

// File: doc/dmem_loader.md
Name: dmem_loader

Overview:
Write-side front end for the 10,240 x 16-bit sample data memory (dmem) in the FIR datapath.
- Accepts a stream of 16-bit input samples over a valid/ready handshake.
- Writes each accepted sample into dmem at a circular write pointer.
- Signals completion after a programmed frame length, so the FIR engine can start reading that frame.

Parameters:
ADDR_W, 14, dmem address width
DATA_W, 16, sample/data width
DEPTH, 10240, number of dmem words; the write pointer wraps from DEPTH-1 to 0
BASE, 0, write pointer value after reset

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a frame when in IDLE
frame_len  input  ADDR_W  samples in the frame; sampled on the start cycle
in_valid  input  1  upstream sample valid
in_data  input  DATA_W  upstream sample
in_ready  output  1  loader can accept a sample this cycle
busy  output  1  high while in LOAD
done  output  1  one-cycle pulse when a frame completes
wr_ptr  output  ADDR_W  next dmem address to be written
sample_cnt  output  ADDR_W  samples accepted in the current frame
checksum  output  DATA_W  running sum (optional feature)
mem_cen  output  1  to dmem cen, active-low chip enable
mem_wen  output  1  to dmem wen, active-low (0 = write)
mem_a  output  ADDR_W  to dmem address
mem_d  output  DATA_W  to dmem write data

Behaviour:
- Reset (asynchronous): state=IDLE, in_ready=0, busy=0, done=0, wr_ptr=BASE, sample_cnt=0, checksum=0, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0.
- A reset asserted mid-frame abandons the frame. No partial done pulse is produced, and the words already written stay in dmem.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches frame_len and clears sample_cnt (and checksum).
  - If frame_len!=0, go to LOAD. If frame_len==0, go to DONE with no writes.
- LOAD:
  - busy=1, in_ready=1 (combinational from state).
  - An accept is in_valid&in_ready at a rising edge. On an accept edge: mem_cen<=0, mem_wen<=0, mem_a<=wr_ptr, mem_d<=in_data, wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1, sample_cnt<=sample_cnt+1.
  - dmem performs the write on the following rising edge, so there is one cycle of latency from accept to the memory write.
  - On a non-accept edge: mem_cen<=1, mem_wen<=1; mem_a and mem_d hold their values.
  - On the accept edge where sample_cnt+1==latched frame_len, go to DONE.
  - Back-to-back accepts (in_valid held high) write one word per cycle.
- DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0.
  - mem_cen<=1, mem_wen<=1 on the DONE edge; the final write completes on that same edge.
  - Next state is IDLE.
- start is ignored outside IDLE. frame_len changes after the start cycle have no effect.
- wr_ptr persists across frames, so consecutive frames fill dmem as a circular buffer. Only rst returns it to BASE.
- Wrap: a write at address DEPTH-1 (9,999 when DEPTH=10,000; 10,239 at default) is followed by a write at address 0. No address >= DEPTH is ever driven.
- frame_len > DEPTH is legal. The oldest data is overwritten and no error is flagged.
- The loader never drives a dmem read; mem_wen=0 only when mem_cen=0.

Optional Feature:
DMEM_LOADER_CKSUM_EN
- Defined: on each accept, checksum <= checksum + in_data (modulo 2^DATA_W). checksum is cleared by rst and by an accepted start, and holds its value after done.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Test Plan:
1. rst=1 mid-run, then released → mem_cen=1, mem_wen=1, wr_ptr=0, done=0, in_ready=0 immediately (asynchronous).
2. start with frame_len=3, samples 9000, 300, 50 sent back-to-back → dmem writes at addresses 0,1,2 on consecutive cycles; done pulses once; wr_ptr=3; a dmem read of address 1 returns 300.
3. Same as scenario 2 but in_valid low for 2 cycles between samples → mem_cen=1 during the gaps, no spurious writes, sample_cnt=3 at done.
4. DEPTH=10000, drive wr_ptr to 9998, frame_len=4, samples 1..4 → writes at 9998, 9999, 0, 1; wr_ptr=2.
5. start with frame_len=0 → done pulses one cycle after start; no mem_cen=0 cycle ever occurs. A start pulse during LOAD → ignored, with frame_len unchanged.
6. With DMEM_LOADER_CKSUM_EN defined, samples 0xFFFF, 0x0002 → checksum=0x0001. Without the macro → checksum=0.
